pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline-stage register carrying an instruction word and its branch-history state.
//  Replaces fixed en/clear stage registers with a DEPTH-entry circular buffer and a valid/ready handshake on both sides.
//  Adds synchronous flush with NOP bubble injection and a saturating back-pressure counter.
//  Sits between any two core stages (IF/ID first); the upstream stage is stalled by in_ready, not by an en line.
// PARAMETERS
//  INST_W        32   instruction width
//  BHT_W         2    branch-history state width
//  DEPTH         2    buffer entries (>=1; need not be a power of 2)
//  BYPASS_READY  0    1: in_ready also high when full and out_ready (combinational ready path); 0: registered-only ready
//  NOP_INST      0    instruction value driven while empty (bubble)
//  CNT_W         32   stall counter width
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous, active-high reset
//  flush      in   1              synchronous flush, highest priority
//  in_valid   in   1              upstream holds a valid inst
//  in_ready   out  1              stage accepts this cycle
//  in_inst    in   INST_W         instruction in
//  in_bht     in   BHT_W          branch-history state in
//  out_valid  out  1              head entry valid
//  out_ready  in   1              downstream consumes head
//  out_inst   out  INST_W         head instruction, NOP_INST when empty
//  out_bht    out  BHT_W          head bht state, 0 when empty
//  occupancy  out  clog2(DEPTH+1) entries held
//  stall_cnt  out  CNT_W          cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): rd_ptr=wr_ptr=0, occupancy=0, all entries 0, stall_cnt=0; out_valid=0, out_inst=NOP_INST, out_bht=0.
//  - push = in_valid && in_ready; pop = out_valid && out_ready. Both evaluated on the same edge.
//  - in_ready = !flush && (occupancy<DEPTH || (BYPASS_READY && out_ready)).
//  - out_valid = (occupancy!=0). No fall-through: data written at edge N is visible at out_* after edge N (1-cycle latency).
//  - push: entry[wr_ptr]<= {in_inst,in_bht}; wr_ptr advances. pop: rd_ptr advances.
//  - Pointers wrap DEPTH-1 -> 0 (explicit compare, not modulo-2^n).
//  - occupancy += push - pop. Push+pop on the same cycle leaves occupancy unchanged, including full with BYPASS_READY=1.
//  - pop on empty: impossible (out_valid=0); out_ready ignored when empty.
//  - flush=1 (sync): next state is occupancy=0, rd_ptr=wr_ptr=0; the same-cycle push is dropped (in_ready=0).
//  - flush=1: a same-cycle pop still completes downstream, but its side effect is overridden by flush. Entry storage is not cleared.
//  - Empty outputs: out_inst=NOP_INST, out_bht=0. No stale data is ever driven.
//  - stall_cnt: +1 on each cycle with out_valid && !out_ready; holds at 2^CNT_W-1; unaffected by flush; cleared only by reset.
//  - rst asserted mid-transfer: all state drops immediately; in-flight handshake is lost by design.
//  - out_* are mux-of-registers only; no combinational path from in_* to out_*.
//  - The only in->out combinational path is out_ready->in_ready, and only when BYPASS_READY=1.
// STRUCTURE
//  - Shared package core_pipe_pkg: NOP_INST default, BHT_W, the bht state encodings (SNT/WNT/WT/ST = 0..3), and the pipe_entry_t packing {inst,bht}.
//  - Sub-module pipe_ring_ptr: wrap-around pointer with an inc and a sync clear.
//    Instantiated twice (rd, wr) to keep non-power-of-2 wrap logic in one place.
//  - Storage: flat register array of DEPTH pipe_entry_t; no RAM macro.
// TESTING
//  1 Reset: rst=1 mid-run with occupancy=2 -> out_valid=0, out_inst=NOP_INST, occupancy=0, stall_cnt=0 with no clock edge.
//  2 Streaming: DEPTH=2, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_inst 0x11,0x22,0x33 one cycle later each; occupancy stays 1.
//  3 Back-pressure: out_ready=0, push 3 -> in_ready drops after 2 accepts, third held upstream, stall_cnt counts 1,2,3...
//    Then out_ready=1 -> order 0x11,0x22,0x33 preserved.
//  4 Wrap: DEPTH=3, 7 push/pop pairs with data 1..7 -> output 1..7 in order, pointers pass 2->0 twice.
//  5 Flush: occupancy=2 with in_valid=1 and flush=1 -> next cycle occupancy=0, out_inst=NOP_INST, the pushed inst never appears.
//  6 Bypass and saturation: BYPASS_READY=1, full, out_ready=1, in_valid=1 -> in_ready=1, occupancy stays DEPTH.
//    With CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// Shared definitions for core pipeline stage registers: default widths,
// bubble instruction, branch-history encodings and the stage entry packing.
package core_pipe_pkg;

    localparam int unsigned PIPE_INST_W = 32;
    localparam int unsigned PIPE_BHT_W  = 2;

    // Instruction value presented downstream while a stage holds nothing
    localparam logic [PIPE_INST_W-1:0] PIPE_NOP_INST = '0;

    // Two-bit saturating branch-history states
    typedef enum logic [PIPE_BHT_W-1:0] {
        BHT_SNT = 2'd0,
        BHT_WNT = 2'd1,
        BHT_WT  = 2'd2,
        BHT_ST  = 2'd3
    } bht_state_e;

    // One stage entry at the default widths: {inst, bht}
    typedef struct packed {
        logic [PIPE_INST_W-1:0] inst;
        logic [PIPE_BHT_W-1:0]  bht;
    } pipe_entry_t;

    // Pack an instruction and its history state into a stage entry
    function automatic pipe_entry_t pack_entry(
        input logic [PIPE_INST_W-1:0] inst,
        input logic [PIPE_BHT_W-1:0]  bht
    );
        pipe_entry_t e;
        e.inst = inst;
        e.bht  = bht;
        return e;
    endfunction

endpackage

// File: rtl/pipe_ring_ptr.sv
// Wrap-around index for a DEPTH-entry ring; DEPTH need not be a power of 2.
module pipe_ring_ptr #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Clear wins over increment; the last slot wraps back to slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == LAST) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: DEPTH-entry ring with valid/ready on both
// sides, synchronous flush with bubble output and a saturating stall counter.
module pipe_stage_elastic
    import core_pipe_pkg::*;
#(
    parameter  int unsigned       INST_W       = PIPE_INST_W,
    parameter  int unsigned       BHT_W        = PIPE_BHT_W,
    parameter  int unsigned       DEPTH        = 2,
    parameter  bit                BYPASS_READY = 1'b0,
    parameter  logic [INST_W-1:0] NOP_INST     = INST_W'(PIPE_NOP_INST),
    parameter  int unsigned       CNT_W        = 32,
    localparam int unsigned       OCC_W        = $clog2(DEPTH + 1),
    localparam int unsigned       PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [BHT_W-1:0]  in_bht,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [BHT_W-1:0]  out_bht,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Entry layout at this instance's widths, same {inst, bht} order as pipe_entry_t
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [BHT_W-1:0]  bht;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head_c;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  occ_q;
    logic [CNT_W-1:0]  stall_q;
    logic              push_c;
    logic              pop_c;
    logic              has_room_c;

    // Handshake: ready from registered occupancy, optionally widened by out_ready
    always_comb begin
        has_room_c = (occ_q < DEPTH_OCC);
        in_ready   = !flush && (has_room_c || (BYPASS_READY && out_ready));
        out_valid  = (occ_q != '0);
        push_c     = in_valid && in_ready;
        pop_c      = out_valid && out_ready;
    end

    // Head mux: registered entry when valid, bubble otherwise
    always_comb begin
        head_c   = mem[rd_ptr];
        out_inst = NOP_INST;
        out_bht  = '0;
        if (out_valid) begin
            out_inst = head_c.inst;
            out_bht  = head_c.bht;
        end
    end

    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

    pipe_ring_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop_c),
        .ptr (rd_ptr)
    );

    pipe_ring_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_c),
        .ptr (wr_ptr)
    );

    // Entry storage; flush leaves contents in place, they are unreachable once empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_c) begin
            mem[wr_ptr] <= '{inst: in_inst, bht: in_bht};
        end
    end

    // Occupancy: flush empties the stage, simultaneous push and pop cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (push_c && !pop_c) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (pop_c && !push_c) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    // Back-pressure counter: saturates, ignores flush, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three configurations driven from shared inputs.
//  u_a: DEPTH=2, registered ready, 32-bit counter
//  u_b: DEPTH=3, registered ready
//  u_c: DEPTH=2, bypass ready, 4-bit counter
module tb_pipe_stage_elastic;
    import core_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [1:0]  in_bht;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b, in_ready_c, out_valid_c;
    logic [31:0] out_inst_a, out_inst_b, out_inst_c;
    logic [1:0]  out_bht_a, out_bht_b, out_bht_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic [31:0] stall_a, stall_b;
    logic [3:0]  stall_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DEPTH(2), .BYPASS_READY(1'b0), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_inst(in_inst), .in_bht(in_bht), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_inst(out_inst_a), .out_bht(out_bht_a), .occupancy(occ_a), .stall_cnt(stall_a));

    pipe_stage_elastic #(.DEPTH(3), .BYPASS_READY(1'b0), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_bht(in_bht), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_inst(out_inst_b), .out_bht(out_bht_b), .occupancy(occ_b), .stall_cnt(stall_b));

    pipe_stage_elastic #(.DEPTH(2), .BYPASS_READY(1'b1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_inst(in_inst), .in_bht(in_bht), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_inst(out_inst_c), .out_bht(out_bht_c), .occupancy(occ_c), .stall_cnt(stall_c));

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_bht = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid_a); end
        checks++; if (out_inst_a !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", out_inst_a); end
        in_valid = 1'b1; in_inst = 32'h11; in_bht = BHT_WT; step();
        in_inst = 32'h22; step();
        in_valid = 1'b0; step();
        checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL pre_reset_occ got %0d exp 2", occ_a); end
        checks++; if (stall_a !== 32'd2) begin errors++; $display("FAIL pre_reset_stall got %0d exp 2", stall_a); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %0b exp 0", out_valid_a); end
        checks++; if (out_inst_a !== 32'h0) begin errors++; $display("FAIL async_rst_inst got %h exp 0", out_inst_a); end
        checks++; if (out_bht_a !== 2'd0) begin errors++; $display("FAIL async_rst_bht got %0d exp 0", out_bht_a); end
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL async_rst_occ got %0d exp 0", occ_a); end
        checks++; if (stall_a !== 32'd0) begin errors++; $display("FAIL async_rst_stall got %0d exp 0", stall_a); end
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] d [3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = d[i]; in_bht = 2'(i + 1);
            #1;
            checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0b exp 1", i, in_ready_a); end
            step();
            checks++; if (out_inst_a !== d[i]) begin errors++; $display("FAIL stream_inst[%0d] got %h exp %h", i, out_inst_a, d[i]); end
            checks++; if (out_bht_a !== 2'(i + 1)) begin errors++; $display("FAIL stream_bht[%0d] got %0d exp %0d", i, out_bht_a, i + 1); end
            checks++; if (occ_a !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occ_a); end
        end
        in_valid = 1'b0; step();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %0b exp 0", out_valid_a); end
        checks++; if (out_inst_a !== 32'h0) begin errors++; $display("FAIL stream_drain_inst got %h exp 0", out_inst_a); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h11; step();
        in_inst = 32'h22; #1;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %0b exp 1", in_ready_a); end
        step();
        in_inst = 32'h33; #1;
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b exp 0", in_ready_a); end
        checks++; if (stall_a !== 32'd1) begin errors++; $display("FAIL bp_stall1 got %0d exp 1", stall_a); end
        for (int k = 2; k <= 4; k++) begin
            step();
            checks++; if (stall_a !== 32'(k)) begin errors++; $display("FAIL bp_stall%0d got %0d exp %0d", k, stall_a, k); end
            checks++; if (out_inst_a !== 32'h11 || occ_a !== 2'd2) begin errors++; $display("FAIL bp_hold got %h/%0d exp 11/2", out_inst_a, occ_a); end
        end
        out_ready = 1'b1; #1;
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL bp_no_bypass got %0b exp 0", in_ready_a); end
        step();
        checks++; if (out_inst_a !== 32'h22 || occ_a !== 2'd1) begin errors++; $display("FAIL bp_drain1 got %h/%0d exp 22/1", out_inst_a, occ_a); end
        step();
        checks++; if (out_inst_a !== 32'h33 || occ_a !== 2'd1) begin errors++; $display("FAIL bp_drain2 got %h/%0d exp 33/1", out_inst_a, occ_a); end
        checks++; if (stall_a !== 32'd4) begin errors++; $display("FAIL bp_stall_hold got %0d exp 4", stall_a); end
        in_valid = 1'b0; step();
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL bp_empty got %0d exp 0", occ_a); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            in_valid = 1'b1; in_inst = 32'(i); in_bht = 2'(i);
            step();
            checks++; if (out_inst_b !== 32'(i) || out_bht_b !== 2'(i)) begin errors++; $display("FAIL wrap_out[%0d] got %h/%0d exp %0d", i, out_inst_b, out_bht_b, i); end
            checks++; if (occ_b !== 2'd1) begin errors++; $display("FAIL wrap_occ[%0d] got %0d exp 1", i, occ_b); end
        end
        in_valid = 1'b0; step();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_inst = 32'(8 + j); step();
        end
        in_valid = 1'b0; #1;
        checks++; if (in_ready_b !== 1'b0 || occ_b !== 2'd3) begin errors++; $display("FAIL wrap_full got %0b/%0d exp 0/3", in_ready_b, occ_b); end
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++; if (out_inst_b !== 32'(8 + j)) begin errors++; $display("FAIL wrap_drain[%0d] got %h exp %0d", j, out_inst_b, 8 + j); end
            step();
        end
        checks++; if (occ_b !== 2'd0 || out_inst_b !== 32'h0) begin errors++; $display("FAIL wrap_empty got %0d/%h exp 0/0", occ_b, out_inst_b); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h11; step();
        in_inst = 32'h22; step();
        in_inst = 32'hAA; in_bht = BHT_ST; flush = 1'b1; #1;
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", in_ready_a); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0) begin errors++; $display("FAIL flush_empty got %0d/%0b exp 0/0", occ_a, out_valid_a); end
        checks++; if (out_inst_a !== 32'h0 || out_bht_a !== 2'd0) begin errors++; $display("FAIL flush_nop got %h/%0d exp 0/0", out_inst_a, out_bht_a); end
        checks++; if (stall_a !== 32'd2) begin errors++; $display("FAIL flush_stall got %0d exp 2", stall_a); end
        out_ready = 1'b1; step();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL flush_ghost got %0b exp 0", out_valid_a); end
        in_valid = 1'b1; in_inst = 32'h55; in_bht = BHT_WNT; step();
        checks++; if (out_inst_a !== 32'h55 || out_bht_a !== 2'd1) begin errors++; $display("FAIL flush_refill got %h/%0d exp 55/1", out_inst_a, out_bht_a); end
    endtask

    task automatic test_bypass_saturation();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h1; step();
        in_inst = 32'h2; step();
        checks++; if (occ_c !== 2'd2) begin errors++; $display("FAIL byp_fill got %0d exp 2", occ_c); end
        out_ready = 1'b1; in_inst = 32'h3; #1;
        checks++; if (in_ready_c !== 1'b1) begin errors++; $display("FAIL byp_ready got %0b exp 1", in_ready_c); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL nobyp_ready got %0b exp 0", in_ready_a); end
        step();
        checks++; if (occ_c !== 2'd2 || out_inst_c !== 32'h2) begin errors++; $display("FAIL byp_step1 got %0d/%h exp 2/2", occ_c, out_inst_c); end
        in_inst = 32'h4; step();
        checks++; if (occ_c !== 2'd2 || out_inst_c !== 32'h3) begin errors++; $display("FAIL byp_step2 got %0d/%h exp 2/3", occ_c, out_inst_c); end
        in_valid = 1'b0; step();
        checks++; if (occ_c !== 2'd1 || out_inst_c !== 32'h4) begin errors++; $display("FAIL byp_step3 got %0d/%h exp 1/4", occ_c, out_inst_c); end
        do_reset();
        in_valid = 1'b1; in_inst = 32'h5; step();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++; if (stall_c !== 4'((k > 15) ? 15 : k)) begin errors++; $display("FAIL sat_stall[%0d] got %0d exp %0d", k, stall_c, (k > 15) ? 15 : k); end
        end
        checks++; if (stall_a !== 32'd20) begin errors++; $display("FAIL wide_stall got %0d exp 20", stall_a); end
    endtask

    // Random traffic against queue models of u_b and u_c
    task automatic test_random();
        logic [33:0] qb[$];
        logic [33:0] qc[$];
        int          sb = 0;
        int          sc = 0;
        logic        rb, rc;
        logic [33:0] hb, hc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            flush     = ($urandom % 16) == 0;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_inst   = $urandom;
            in_bht    = 2'($urandom);
            #1;
            rb = !flush && (qb.size() < 3);
            rc = !flush && ((qc.size() < 2) || out_ready);
            hb = (qb.size() != 0) ? qb[0] : 34'h0;
            hc = (qc.size() != 0) ? qc[0] : 34'h0;
            checks++; if (in_ready_b !== rb || in_ready_c !== rc) begin errors++; $display("FAIL rnd_ready[%0d] got %0b%0b exp %0b%0b", n, in_ready_b, in_ready_c, rb, rc); end
            checks++; if (out_valid_b !== (qb.size() != 0) || {out_inst_b, out_bht_b} !== hb) begin errors++; $display("FAIL rnd_out_b[%0d] got %0b/%h exp %h", n, out_valid_b, {out_inst_b, out_bht_b}, hb); end
            checks++; if (out_valid_c !== (qc.size() != 0) || {out_inst_c, out_bht_c} !== hc) begin errors++; $display("FAIL rnd_out_c[%0d] got %0b/%h exp %h", n, out_valid_c, {out_inst_c, out_bht_c}, hc); end
            checks++; if (occ_b !== 2'(qb.size()) || occ_c !== 2'(qc.size())) begin errors++; $display("FAIL rnd_occ[%0d] got %0d/%0d exp %0d/%0d", n, occ_b, occ_c, qb.size(), qc.size()); end
            checks++; if (stall_b !== 32'(sb) || stall_c !== 4'(sc)) begin errors++; $display("FAIL rnd_stall[%0d] got %0d/%0d exp %0d/%0d", n, stall_b, stall_c, sb, sc); end
            if (qb.size() != 0 && !out_ready) sb++;
            if (qc.size() != 0 && !out_ready && sc != 15) sc++;
            if (flush) begin
                qb.delete();
                qc.delete();
            end else begin
                if (qb.size() != 0 && out_ready) void'(qb.pop_front());
                if (qc.size() != 0 && out_ready) void'(qc.pop_front());
                if (in_valid && rb) qb.push_back({in_inst, in_bht});
                if (in_valid && rc) qc.push_back({in_inst, in_bht});
            end
            step();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_streaming();
        test_back_pressure();
        test_wrap();
        test_flush();
        test_bypass_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
